branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised direct-mapped branch target buffer with saturating-counter direction prediction.
//  Sits beside the fetch stage of the pipelined core:
//   - IF presents its PC and gets a predicted next PC in the same cycle.
//   - EX reports each resolved branch/jump one update per cycle, trains the table, and removes most taken-branch flushes.
//  Mispredict detection and flush generation remain in the fetch logic; this block only predicts and learns.
// PARAMETERS
//  XLEN      32  address/PC width
//  ENTRIES   64  table entries; power of 2, >=2; IDX = log2(ENTRIES)
//  CTR_BITS  2   direction counter width, 1..4; MSB set = predict taken
// PORTS
//  clk             in   1     clock; all state updates on posedge
//  rst             in   1     synchronous, active-high reset
//  lk_pc           in   XLEN  fetch PC to look up (IF stage)
//  lk_hit          out  1     entry valid and tag matches lk_pc
//  lk_taken        out  1     lk_hit & counter MSB
//  lk_next_pc      out  XLEN  lk_taken ? stored target : lk_pc+4
//  upd_valid       in   1     resolved control-flow instruction in EX this cycle
//  upd_pc          in   XLEN  PC of resolved instruction
//  upd_taken       in   1     actual outcome (jumps always 1)
//  upd_is_jump     in   1     JAL/JALR: counter forced to max
//  upd_target      in   XLEN  actual target (pc_imm or rs1_imm)
//  upd_mispredict  in   1     fetch logic flagged a redirect for this update
//  inv_all         in   1     invalidate every entry (FENCE.I / self-modifying code)
//  stat_updates    out  32    count of accepted updates
//  stat_mispred    out  32    count of accepted updates with upd_mispredict=1
// BEHAVIOUR
//  - Entry fields:
//      valid(1), tag(XLEN-IDX-2), target(XLEN), ctr(CTR_BITS).
//      index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
//  - Lookup timing:
//      Purely combinational from registered table; 0-cycle latency.
//      No bypass of a same-cycle update: lookup sees pre-edge state.
//  - Update timing:
//      Takes effect at the posedge where upd_valid=1; visible to lookups the following cycle.
//  - Update on hit (valid & tag match at upd index):
//      Jump: ctr = all-ones.
//      Taken branch: ctr = sat_inc(ctr).
//      Not-taken branch: ctr = sat_dec(ctr).
//      Target is written only when upd_taken=1.
//      Counters saturate at 0 and 2^CTR_BITS-1 and never wrap.
//  - Update on miss:
//      upd_taken=1: allocate or overwrite the entry. valid=1, tag, target.
//        ctr = all-ones for jumps, else 2^(CTR_BITS-1) (weakly taken).
//      upd_taken=0: table unchanged (no allocation).
//  - Aliasing: a different tag at the same index is a miss; allocation replaces the old entry.
//  - lk_next_pc arithmetic: lk_pc+4 is modulo 2^XLEN; 0xFFFFFFFC wraps to 0x0.
//  - inv_all:
//      Clears all valid bits at the next posedge.
//      A same-cycle upd_valid is dropped; inv_all wins.
//      Stats still count that update.
//  - Reset (rst=1 at posedge):
//      Valid bits cleared and ctr set to 0 in all entries; target/tag may stay unreset.
//      stat_* = 0; any upd_valid or inv_all in that cycle is ignored.
//      Combinational outputs during and after reset follow an empty table:
//        lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+4.
//      Reset mid-training loses all learned state; no partial entries survive.
// CONFIGURATION
//  BP_STATS_EN defined:
//    stat_updates increments on every upd_valid outside reset.
//    stat_mispred increments when upd_valid & upd_mispredict.
//    Both saturate at 0xFFFFFFFF.
//  BP_STATS_EN undefined:
//    Counters not built; stat_updates/stat_mispred tied to 0; upd_mispredict ignored.
// TESTING
//  1. rst 1 cycle; lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_next_pc=0x104.
//  2. upd pc=0x100 taken target=0x40 branch; next cycle lk_pc=0x100 -> hit=1, taken=1, next_pc=0x40 (ctr=2).
//  3. Then three not-taken updates pc=0x100:
//     - after 1st, lookup taken=0, next_pc=0x104;
//     - ctr 2->1->0->0 (saturates);
//     - target stays 0x40.
//  4. Alias, ENTRIES=64: after step 2, lk_pc=0x200 -> hit=0.
//     Taken upd pc=0x200 target=0x80 -> lk 0x200 next_pc=0x80; lk 0x100 hit=0.
//  5. Same-cycle upd pc=0x300 taken and lk_pc=0x300 -> hit=0 that cycle; hit=1, next_pc=target the next cycle.
//  6. inv_all with a same-cycle taken upd pc=0x100 -> all lookups miss next cycle.
//     With BP_STATS_EN, 5 updates (2 with mispredict) give stat_updates=5, stat_mispred=2;
//     without the macro, both read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle for the branch predictor: IF lookup, EX update, invalidate, stats.
// master = core side (drives lookup PC, updates, invalidate); slave = predictor.
// Lookup outputs are combinational; updates have no backpressure (one per cycle accepted).
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    // IF-stage lookup
    logic [XLEN-1:0] lk_pc;
    logic            lk_hit;
    logic            lk_taken;
    logic [XLEN-1:0] lk_next_pc;
    // EX-stage resolution
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_is_jump;
    logic [XLEN-1:0] upd_target;
    logic            upd_mispredict;
    // maintenance and statistics
    logic            inv_all;
    logic [31:0]     stat_updates;
    logic [31:0]     stat_mispred;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target,
               upd_mispredict, inv_all,
        input  lk_hit, lk_taken, lk_next_pc, stat_updates, stat_mispred
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target,
               upd_mispredict, inv_all,
        output lk_hit, lk_taken, lk_next_pc, stat_updates, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, beside the fetch stage.
// Lookup: 0-cycle combinational from registered table; update visible the cycle after its edge.
// No backpressure: one update per cycle always accepted; inv_all overrides a same-cycle update.
// Ports: clk, rst (sync, active-high); bp (branch_predictor_if.slave) carrying lk_*, upd_*,
//        inv_all and stat_* signals.
// Optional macro BP_STATS_EN: builds saturating update/mispredict counters; otherwise stat_* read 0.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_ONE  = 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_HALF = CTR_ONE << (CTR_BITS - 1);
    localparam logic [XLEN-1:0]     PC_STEP  = 4;

    // table state
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (combinational). Gated by rst so the table looks empty during
    // the reset cycle too, not only after it.
    // ------------------------------------------------------------------
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bp.lk_pc[IDX+1:2];
    assign lk_tag   = bp.lk_pc[XLEN-1:IDX+2];
    assign lk_hit   = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];

    assign bp.lk_hit     = lk_hit;
    assign bp.lk_taken   = lk_taken;
    assign bp.lk_next_pc = lk_taken ? target_q[lk_idx] : (bp.lk_pc + PC_STEP);

    // ------------------------------------------------------------------
    // Update next-state
    // ------------------------------------------------------------------
    logic [IDX-1:0]      u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic [CTR_BITS-1:0] u_ctr;
    logic                u_hit;
    logic [CTR_BITS-1:0] ctr_d;
    logic                ctr_we;
    logic                tag_we;
    logic                tgt_we;

    assign u_idx = bp.upd_pc[IDX+1:2];
    assign u_tag = bp.upd_pc[XLEN-1:IDX+2];
    assign u_ctr = ctr_q[u_idx];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        valid_d = valid_q;
        ctr_d   = u_ctr;
        ctr_we  = 1'b0;
        tag_we  = 1'b0;
        tgt_we  = 1'b0;
        if (bp.inv_all) begin
            // invalidate wins over any same-cycle training
            valid_d = '0;
        end else if (bp.upd_valid) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                tgt_we = bp.upd_taken;
                if (bp.upd_is_jump) begin
                    ctr_d = CTR_MAX;
                end else if (bp.upd_taken) begin
                    ctr_d = (u_ctr == CTR_MAX) ? u_ctr : (u_ctr + CTR_ONE);
                end else begin
                    ctr_d = (u_ctr == '0) ? u_ctr : (u_ctr - CTR_ONE);
                end
            end else if (bp.upd_taken) begin
                // allocate (replacing any alias); not-taken misses leave table alone
                valid_d[u_idx] = 1'b1;
                ctr_we         = 1'b1;
                tag_we         = 1'b1;
                tgt_we         = 1'b1;
                ctr_d          = bp.upd_is_jump ? CTR_MAX : CTR_HALF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (ctr_we) begin
                ctr_q[u_idx] <= ctr_d;
            end
        end
    end

    // tag/target need no reset: they are meaningless while valid is clear
    always_ff @(posedge clk) begin
        if (!rst && tag_we) begin
            tag_q[u_idx] <= u_tag;
        end
        if (!rst && tgt_we) begin
            target_q[u_idx] <= bp.upd_target;
        end
    end

    // byte-offset bits of the PCs do not participate in indexing
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] stat_upd_q;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_upd_d;
    logic [31:0] stat_mis_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        // counted even when inv_all drops the update
        if (bp.upd_valid) begin
            if (stat_upd_q != 32'hFFFF_FFFF) begin
                stat_upd_d = stat_upd_q + 32'd1;
            end
            if (bp.upd_mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_d = stat_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign bp.stat_updates = stat_upd_q;
    assign bp.stat_mispred = stat_mis_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = bp.upd_mispredict;
    assign bp.stat_updates   = '0;
    assign bp.stat_mispred   = '0;
`endif

endmodule
